// File: rtl/pio_edge_capture_bank.sv
// pio_edge_capture_bank: Avalon-MM input PIO with synchroniser, per-bit edge
// select, write-one-to-clear edge capture, readable IRQ status and a level IRQ.
// Optional per-bit debounce is built when PIO_DEBOUNCE_EN is defined; without it
// the debounce period register at address 7 reads 0 and ignores writes.
module pio_edge_capture_bank #(
    parameter int              WIDTH       = 10,
    parameter int              SYNC_STAGES = 2,
    parameter int              DB_W        = 16,
    parameter logic [DB_W-1:0] DB_RESET    = 16'd1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES = {WIDTH{1'b1}};

    // Parameter sanity: a bad build should stop at elaboration, not in silicon.
    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DB_W < 1 || DB_W > 32 ||
        $bits(DB_RESET) != DB_W) begin : g_param_err
        $error("pio_edge_capture_bank: illegal parameter combination");
    end

    // Zero-extend a channel vector onto the 32-bit read bus.
    function automatic logic [31:0] zext_w(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Bus decode
    logic             w_wr;
    logic             w_wr_mask;
    logic             w_wr_cap;
    logic             w_wr_rise;
    logic             w_wr_fall;
    logic [WIDTH-1:0] w_wdata;
    logic             w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_mask = w_wr & (address == 3'd2);
    assign w_wr_cap  = w_wr & (address == 3'd3);
    assign w_wr_rise = w_wr & (address == 3'd4);
    assign w_wr_fall = w_wr & (address == 3'd5);
    assign w_wdata   = writedata[WIDTH-1:0];
    // Upper write-data bits are don't-care for narrow banks.
    assign w_unused  = ^writedata;

    // Synchroniser
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Shift the asynchronous inputs through the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {(SYNC_STAGES*WIDTH){1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

    // Value feeding the level register: debounced or straight from the chain.
    logic [WIDTH-1:0] w_db_out;
    logic [31:0]      w_db_rd;

`ifdef PIO_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] DB_ONE  = {{(DB_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0][DB_W-1:0] r_cnt;
    logic [WIDTH-1:0][DB_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0]           r_stable;
    logic [DB_W-1:0]            r_db_period;
    logic                       w_wr_db;

    assign w_wr_db  = w_wr & (address == 3'd7);
    assign w_db_out = r_stable;

    // Next count value per channel, kept at counter width.
    always_comb begin
        w_cnt_inc = {(WIDTH*DB_W){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_inc[i] = r_cnt[i] + DB_ONE;
        end
    end

    // Zero-extend the period for read-back.
    always_comb begin
        w_db_rd = 32'd0;
        w_db_rd[DB_W-1:0] = r_db_period;
    end

    // Debounce period register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_period <= DB_RESET;
        end else if (w_wr_db) begin
            r_db_period <= writedata[DB_W-1:0];
        end else begin
            r_db_period <= r_db_period;
        end
    end

    // Per-channel stability counters; a change commits only after it has
    // persisted for db_period clocks, any glitch restarts the count, and a
    // period of zero turns the stage into a plain one-clock delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= {(WIDTH*DB_W){1'b0}};
            r_stable <= W_ZERO;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_wr_db) begin
                    r_cnt[i] <= DB_ZERO;
                end else if (w_sync_out[i] == r_stable[i]) begin
                    r_cnt[i] <= DB_ZERO;
                end else if ((r_db_period == DB_ZERO) || (w_cnt_inc[i] == r_db_period)) begin
                    r_stable[i] <= w_sync_out[i];
                    r_cnt[i]    <= DB_ZERO;
                end else begin
                    r_cnt[i] <= w_cnt_inc[i];
                end
            end
        end
    end
`else
    assign w_db_out = w_sync_out;
    assign w_db_rd  = 32'd0;
`endif

    // Core registers
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_status;

    assign w_rise   = r_level & ~r_prev & r_rise_en;
    assign w_fall   = ~r_level & r_prev & r_fall_en;
    assign w_status = r_edge_capture & r_irq_mask;
    assign irq      = |w_status;

    // Clear mask only exists on a write to the capture register.
    always_comb begin
        if (w_wr_cap) begin
            w_w1c = w_wdata;
        end else begin
            w_w1c = W_ZERO;
        end
    end

    // Level/previous pipeline for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= W_ZERO;
            r_prev  <= W_ZERO;
        end else begin
            r_level <= w_db_out;
            r_prev  <= r_level;
        end
    end

    // Software-writable control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= W_ZERO;
            r_rise_en  <= W_ONES;
            r_fall_en  <= W_ONES;
        end else begin
            r_irq_mask <= w_wr_mask ? w_wdata : r_irq_mask;
            r_rise_en  <= w_wr_rise ? w_wdata : r_rise_en;
            r_fall_en  <= w_wr_fall ? w_wdata : r_fall_en;
        end
    end

    // Edge capture: a new edge overrides a same-cycle clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_capture <= W_ZERO;
        end else begin
            r_edge_capture <= (r_edge_capture & ~w_w1c) | w_rise | w_fall;
        end
    end

    // Read mux, evaluated every cycle regardless of chipselect.
    logic [31:0] w_rd_mux;
    always_comb begin
        w_rd_mux = 32'd0;
        case (address)
            3'd0:    w_rd_mux = zext_w(r_level);
            3'd2:    w_rd_mux = zext_w(r_irq_mask);
            3'd3:    w_rd_mux = zext_w(r_edge_capture);
            3'd4:    w_rd_mux = zext_w(r_rise_en);
            3'd5:    w_rd_mux = zext_w(r_fall_en);
            3'd6:    w_rd_mux = zext_w(w_status);
            3'd7:    w_rd_mux = w_db_rd;
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Registered read data, one cycle after the address is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            readdata <= w_rd_mux;
        end
    end

endmodule

// File: tb/tb_pio_edge_capture_bank.sv
// Directed bench for pio_edge_capture_bank (default parameters).
module tb_pio_edge_capture_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  in_port;
    logic        irq;

    int total = 0;
    int bad   = 0;

    pio_edge_capture_bank dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [8];
        logic [31:0] rd;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = 10'h000;
        #23;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL reset_readdata got=%h want=0", readdata); end
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) exp_v[i] = 32'd0;
        exp_v[4] = 32'h3FF;
        exp_v[5] = 32'h3FF;
`ifdef PIO_DEBOUNCE_EN
        exp_v[7] = 32'd1000;
`endif
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            total++;
            if (rd !== exp_v[a]) begin
                bad++;
                $display("FAIL reset_read addr=%0d got=%h want=%h", a, rd, exp_v[a]);
            end
        end
    endtask

    task automatic test_sync_latency();
        logic [31:0] rd;
        bus_write(3'd2, 32'h008);
        address = 3'd0;
        in_port = 10'h008;
        tick();
        tick();
        tick();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL lat_irq_early got=%b want=0", irq); end
        tick();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL lat_irq_edge3 got=%b want=1", irq); end
        total++;
        if (readdata !== 32'h008) begin bad++; $display("FAIL lat_data got=%h want=008", readdata); end
        bus_read(3'd6, rd);
        total++;
        if (rd !== 32'h008) begin bad++; $display("FAIL lat_status got=%h want=008", rd); end
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h008) begin bad++; $display("FAIL lat_capture got=%h want=008", rd); end
        bus_write(3'd3, 32'h008);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL lat_irq_clr got=%b want=0", irq); end
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h000) begin bad++; $display("FAIL lat_capture_clr got=%h want=000", rd); end
    endtask

    task automatic test_edge_select();
        logic [31:0] rd;
        bus_write(3'd4, 32'h000);
        bus_write(3'd5, 32'h001);
        in_port = 10'h000;
        repeat (5) tick();
        in_port[0] = 1'b1;
        repeat (5) tick();
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h000) begin bad++; $display("FAIL sel_rise_ignored got=%h want=000", rd); end
        in_port[0] = 1'b0;
        repeat (5) tick();
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h001) begin bad++; $display("FAIL sel_fall_capture got=%h want=001", rd); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        bus_write(3'd2, 32'h001);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL col_irq_pending got=%b want=1", irq); end
        bus_write(3'd4, 32'h001);
        in_port[0] = 1'b1;
        tick();
        tick();
        tick();
        bus_write(3'd3, 32'h001);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h001) begin bad++; $display("FAIL col_edge_wins got=%h want=001", rd); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL col_irq got=%b want=1", irq); end
        bus_write(3'd3, 32'h001);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h000) begin bad++; $display("FAIL col_later_clear got=%h want=000", rd); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL col_irq_clear got=%b want=0", irq); end
    endtask

`ifdef PIO_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] rd;
        bus_write(3'd4, 32'h3FF);
        bus_write(3'd7, 32'd4);
        bus_write(3'd3, 32'h3FF);
        in_port[5] = 1'b1;
        repeat (3) tick();
        in_port[5] = 1'b0;
        repeat (8) tick();
        bus_read(3'd0, rd);
        total++;
        if (rd[5] !== 1'b0) begin bad++; $display("FAIL db_glitch_data got=%h want_bit5=0", rd); end
        bus_read(3'd3, rd);
        total++;
        if (rd[5] !== 1'b0) begin bad++; $display("FAIL db_glitch_capture got=%h want_bit5=0", rd); end
        in_port[5] = 1'b1;
        repeat (12) tick();
        bus_read(3'd0, rd);
        total++;
        if (rd[5] !== 1'b1) begin bad++; $display("FAIL db_hold_data got=%h want_bit5=1", rd); end
        bus_read(3'd3, rd);
        total++;
        if (rd[5] !== 1'b1) begin bad++; $display("FAIL db_hold_capture got=%h want_bit5=1", rd); end
    endtask
`endif

    task automatic test_mid_reset();
        logic [31:0] rd;
        bus_write(3'd4, 32'h3FF);
        bus_write(3'd5, 32'h3FF);
        bus_write(3'd2, 32'h3FF);
        in_port = 10'h0F0;
        repeat (6) tick();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL mrst_irq_before got=%b want=1", irq); end
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL mrst_irq_async got=%b want=0", irq); end
        total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL mrst_readdata got=%h want=0", readdata); end
        in_port = 10'h000;
        #10;
        reset_n = 1'b1;
        tick();
        bus_read(3'd2, rd);
        total++;
        if (rd !== 32'h000) begin bad++; $display("FAIL mrst_mask got=%h want=000", rd); end
        bus_read(3'd3, rd);
        total++;
        if (rd !== 32'h000) begin bad++; $display("FAIL mrst_capture got=%h want=000", rd); end
        bus_read(3'd4, rd);
        total++;
        if (rd !== 32'h3FF) begin bad++; $display("FAIL mrst_rise_en got=%h want=3ff", rd); end
        bus_read(3'd5, rd);
        total++;
        if (rd !== 32'h3FF) begin bad++; $display("FAIL mrst_fall_en got=%h want=3ff", rd); end
        bus_read(3'd0, rd);
        total++;
        if (rd !== 32'h000) begin bad++; $display("FAIL mrst_data got=%h want=000", rd); end
    endtask

    initial begin
        test_reset();
        test_sync_latency();
        test_edge_select();
        test_w1c_collision();
`ifdef PIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
